// File: rtl/stream_lane_dwc_pkg.sv
// Shared types and helpers for the lane-granular stream width converter.
package stream_lane_dwc_pkg;

  typedef enum logic [1:0] {DWC_EQUAL, DWC_UP, DWC_DOWN} dwc_mode_e;

  typedef enum logic {IDLE, EMIT} scatter_state_e;

  function automatic int unsigned padded_bits(input int unsigned n);
    return ((n + 7) / 8) * 8;
  endfunction

  function automatic dwc_mode_e dwc_mode(input int unsigned pe_in, input int unsigned pe_out);
    if (pe_in == pe_out) return DWC_EQUAL;
    if (pe_out > pe_in) return DWC_UP;
    return DWC_DOWN;
  endfunction

endpackage

// File: rtl/stream_lane_dwc_skid.sv
// Two-entry register slice with registered ready; ready is held low through reset.
module stream_skid #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             ready_q, ready_d;
  logic             s_fire, m_fire;

  always_comb begin
    s_fire       = s_valid && ready_q;
    m_fire       = out_valid_q && m_ready;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (!out_valid_q || m_fire) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = s_fire;
        if (s_fire) out_data_d = s_data;
      end
    end else if (s_fire) begin
      skid_valid_d = 1'b1;
      skid_data_d  = s_data;
    end
    ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      ready_q      <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      ready_q      <= ready_d;
    end
  end

  assign s_ready = ready_q;
  assign m_valid = out_valid_q;
  assign m_data  = out_data_q;

endmodule

// File: rtl/stream_lane_dwc.sv
// Lane-granular AXI-Stream width converter: gather, scatter or pass-through slice.
// Optional tlast support via STREAM_LANE_DWC_TLAST_EN.
module stream_lane_dwc
  import stream_lane_dwc_pkg::*;
#(
  parameter int unsigned W      = 4,
  parameter int unsigned PE_IN  = 1,
  parameter int unsigned PE_OUT = 1
) (
  input  logic                              ap_clk,
  input  logic                              ap_rst_n,
  output logic                              s_axis_tready,
  input  logic                              s_axis_tvalid,
  input  logic [padded_bits(PE_IN*W)-1:0]   s_axis_tdata,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tvalid,
  output logic [padded_bits(PE_OUT*W)-1:0]  m_axis_tdata
`ifdef STREAM_LANE_DWC_TLAST_EN
  ,
  input  logic                              s_axis_tlast,
  output logic                              m_axis_tlast
`endif
);

  localparam int unsigned IW  = PE_IN * W;
  localparam int unsigned OW  = PE_OUT * W;
  localparam int unsigned OPW = padded_bits(OW);
  localparam dwc_mode_e   MODE = dwc_mode(PE_IN, PE_OUT);

  logic s_last;
  logic m_last;
  logic unused_in;

  assign unused_in = ^s_axis_tdata;

`ifdef STREAM_LANE_DWC_TLAST_EN
  assign s_last       = s_axis_tlast;
  assign m_axis_tlast = m_last;
`else
  logic unused_last;
  assign s_last      = 1'b0;
  assign unused_last = m_last;
`endif

  if ((PE_IN % PE_OUT != 0) && (PE_OUT % PE_IN != 0)) begin : g_bad_ratio
    $error("stream_lane_dwc: PE_IN and PE_OUT must be integer multiples of one another");
  end

  if (MODE == DWC_EQUAL) begin : g_equal
    logic [IW:0] skid_out;

    stream_skid #(.WIDTH(IW + 1)) u_skid (
      .clk     (ap_clk),
      .rst_n   (ap_rst_n),
      .s_valid (s_axis_tvalid),
      .s_ready (s_axis_tready),
      .s_data  ({s_last, s_axis_tdata[IW-1:0]}),
      .m_valid (m_axis_tvalid),
      .m_ready (m_axis_tready),
      .m_data  (skid_out)
    );

    assign m_axis_tdata = OPW'(skid_out[IW-1:0]);
    assign m_last       = skid_out[IW];

  end else if (MODE == DWC_UP) begin : g_up
    localparam int unsigned K  = PE_OUT / PE_IN;
    localparam int unsigned CW = $clog2(K);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [OW-1:0] gather_q, gather_d;
    logic [OW-1:0] out_q, out_d;
    logic          vld_q, vld_d;
    logic          last_q, last_d;
    logic          run_q;
    logic          s_fire, m_fire, done;

    always_comb begin
      // Stall only when the next completion would overwrite an unaccepted word.
      s_axis_tready = run_q && !(vld_q && !m_axis_tready && (cnt_q == CW'(K - 1) || s_last));
      s_fire   = s_axis_tvalid && s_axis_tready;
      m_fire   = vld_q && m_axis_tready;
      done     = s_fire && (cnt_q == CW'(K - 1) || s_last);
      gather_d = gather_q;
      cnt_d    = cnt_q;
      out_d    = out_q;
      last_d   = last_q;
      vld_d    = vld_q && !m_fire;
      if (s_fire) begin
        gather_d[cnt_q*IW +: IW] = s_axis_tdata[IW-1:0];
        cnt_d = cnt_q + CW'(1);
      end
      // Gather is cleared on completion so a flushed partial word has zero upper lanes.
      if (done) begin
        out_d    = gather_d;
        last_d   = s_last;
        vld_d    = 1'b1;
        gather_d = '0;
        cnt_d    = '0;
      end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
        cnt_q    <= '0;
        gather_q <= '0;
        out_q    <= '0;
        vld_q    <= 1'b0;
        last_q   <= 1'b0;
        run_q    <= 1'b0;
      end else begin
        cnt_q    <= cnt_d;
        gather_q <= gather_d;
        out_q    <= out_d;
        vld_q    <= vld_d;
        last_q   <= last_d;
        run_q    <= 1'b1;
      end
    end

    assign m_axis_tvalid = vld_q;
    assign m_axis_tdata  = OPW'(out_q);
    assign m_last        = last_q;

  end else begin : g_down
    localparam int unsigned K  = PE_IN / PE_OUT;
    localparam int unsigned CW = $clog2(K);

    scatter_state_e state_q, state_d;
    logic [CW-1:0]  idx_q, idx_d;
    logic [IW-1:0]  word_q, word_d;
    logic           last_q, last_d;
    logic           run_q;
    logic           s_fire, m_fire, at_end;

    always_comb begin
      at_end        = (idx_q == CW'(K - 1));
      s_axis_tready = run_q && (state_q == IDLE || (at_end && m_axis_tready));
      m_axis_tvalid = (state_q == EMIT);
      m_axis_tdata  = OPW'(word_q[idx_q*OW +: OW]);
      m_last        = last_q && at_end;
      s_fire        = s_axis_tvalid && s_axis_tready;
      m_fire        = m_axis_tvalid && m_axis_tready;
      state_d       = state_q;
      idx_d         = idx_q;
      word_d        = word_q;
      last_d        = last_q;
      // An input accept in EMIT only happens together with the final slice leaving.
      if (s_fire) begin
        state_d = EMIT;
        word_d  = s_axis_tdata[IW-1:0];
        idx_d   = '0;
        last_d  = s_last;
      end else if (m_fire) begin
        if (at_end) state_d = IDLE;
        else        idx_d   = idx_q + CW'(1);
      end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
        state_q <= IDLE;
        idx_q   <= '0;
        word_q  <= '0;
        last_q  <= 1'b0;
        run_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        idx_q   <= idx_d;
        word_q  <= word_d;
        last_q  <= last_d;
        run_q   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_stream_lane_dwc.sv
// Randomized bench for three converter instances (equal 2->2, up 1->4, down 4->2)
// checked every cycle against a lane-queue model, plus literal directed cases.
module tb_stream_lane_dwc;

  localparam int PI [3] = '{2, 1, 4};
  localparam int PO [3] = '{2, 4, 2};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid [3];
  logic        s_ready [3];
  logic        s_last  [3];
  logic        m_valid [3];
  logic        m_ready [3];
  logic [15:0] s_data  [3];
  logic [15:0] m_data  [3];
  logic [7:0]  eq_md;
  logic [15:0] up_md;
  logic [7:0]  dn_md;
`ifdef STREAM_LANE_DWC_TLAST_EN
  logic        m_last  [3];
  logic        outlst  [3][16];
`endif

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc_g = 0;

  logic [3:0]  lb [3][64];
  int          hd [3];
  int          oc [3];
  logic [15:0] outlog [3][16];
  int          outcyc [3][16];
  int          outn [3];
  logic        acc [3];
  logic [15:0] dw [8];
  logic        dl [8];

  always #5 clk = ~clk;

  always_comb begin
    m_data[0] = {8'h00, eq_md};
    m_data[1] = up_md;
    m_data[2] = {8'h00, dn_md};
  end

  stream_lane_dwc #(.W(4), .PE_IN(2), .PE_OUT(2)) u_eq (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .s_axis_tready(s_ready[0]), .s_axis_tvalid(s_valid[0]), .s_axis_tdata(s_data[0][7:0]),
    .m_axis_tready(m_ready[0]), .m_axis_tvalid(m_valid[0]), .m_axis_tdata(eq_md)
`ifdef STREAM_LANE_DWC_TLAST_EN
    , .s_axis_tlast(s_last[0]), .m_axis_tlast(m_last[0])
`endif
  );

  stream_lane_dwc #(.W(4), .PE_IN(1), .PE_OUT(4)) u_up (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .s_axis_tready(s_ready[1]), .s_axis_tvalid(s_valid[1]), .s_axis_tdata(s_data[1][7:0]),
    .m_axis_tready(m_ready[1]), .m_axis_tvalid(m_valid[1]), .m_axis_tdata(up_md)
`ifdef STREAM_LANE_DWC_TLAST_EN
    , .s_axis_tlast(s_last[1]), .m_axis_tlast(m_last[1])
`endif
  );

  stream_lane_dwc #(.W(4), .PE_IN(4), .PE_OUT(2)) u_dn (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .s_axis_tready(s_ready[2]), .s_axis_tvalid(s_valid[2]), .s_axis_tdata(s_data[2]),
    .m_axis_tready(m_ready[2]), .m_axis_tvalid(m_valid[2]), .m_axis_tdata(dn_md)
`ifdef STREAM_LANE_DWC_TLAST_EN
    , .s_axis_tlast(s_last[2]), .m_axis_tlast(m_last[2])
`endif
  );

  task automatic chk(input string nm, input int d, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d @cyc %0d: got %h expected %h", nm, d, cyc_g, act, exp);
    end
  endtask

  // Model: every DUT is a lane FIFO; words leave in PO-lane chunks once the
  // mode's occupancy rule says a word is presentable.
  initial begin
    for (int d = 0; d < 3; d++) begin hd[d] = 0; oc[d] = 0; outn[d] = 0; end
    forever begin
      @(negedge clk);
      #2;
      cyc_g++;
      for (int d = 0; d < 3; d++) begin
        int po, pi, o;
        logic ev, er;
        logic [15:0] e;
        po = PO[d]; pi = PI[d]; o = oc[d];
        if (!rst_n) begin
          chk("rst_m_valid", d, 16'(m_valid[d]), 16'h0);
          chk("rst_s_ready", d, 16'(s_ready[d]), 16'h0);
          hd[d] = 0; oc[d] = 0;
          continue;
        end
        if (d == 0) begin
          ev = (o > 0);
          er = (o < 2 * pi);
        end else if (d == 1) begin
          ev = (o >= po);
          er = !(ev && !m_ready[d] && ((o - po) == (po - pi) || s_last[d]));
        end else begin
          ev = (o > 0);
          er = (o == 0) || (o == po && m_ready[d]);
        end
        chk("m_valid", d, 16'(m_valid[d]), 16'(ev));
        chk("s_ready", d, 16'(s_ready[d]), 16'(er));
        if (ev) begin
          e = '0;
          for (int i = 0; i < po; i++) e[i*4 +: 4] = lb[d][(hd[d] + i) % 64];
          chk("m_data", d, m_data[d], e);
        end
        if (m_valid[d] && m_ready[d]) begin
          if (outn[d] < 16) begin
            outlog[d][outn[d]] = m_data[d];
            outcyc[d][outn[d]] = cyc_g;
`ifdef STREAM_LANE_DWC_TLAST_EN
            outlst[d][outn[d]] = m_last[d];
`endif
          end
          outn[d]++;
          if (oc[d] >= po) begin hd[d] = (hd[d] + po) % 64; oc[d] -= po; end
        end
        if (s_valid[d] && s_ready[d]) begin
          for (int i = 0; i < pi; i++) begin
            lb[d][(hd[d] + oc[d]) % 64] = s_data[d][i*4 +: 4];
            oc[d]++;
          end
          if (d == 1 && s_last[d]) begin
            while (oc[d] % po != 0) begin
              lb[d][(hd[d] + oc[d]) % 64] = 4'h0;
              oc[d]++;
            end
          end
        end
      end
    end
  end

  task automatic rand_phase(input int ncyc, input int p_ready, input int p_valid);
    repeat (ncyc) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (!s_valid[d] || acc[d]) begin
          s_valid[d] = ($urandom % 100) < p_valid;
          s_data[d]  = 16'($urandom);
        end
        m_ready[d] = ($urandom % 100) < p_ready;
      end
      #1;
      for (int d = 0; d < 3; d++) acc[d] = s_valid[d] && s_ready[d];
    end
  endtask

  task automatic idle_drain();
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin s_valid[d] = 1'b0; s_last[d] = 1'b0; m_ready[d] = 1'b1; acc[d] = 1'b0; end
    repeat (10) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin s_valid[d] = 1'b0; acc[d] = 1'b0; end
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("async_rst_m_valid", d, 16'(m_valid[d]), 16'h0);
      chk("async_rst_s_ready", d, 16'(s_ready[d]), 16'h0);
    end
    repeat (3) @(negedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  // Drives dw[0..n-1] into one DUT (holding each until accepted) with a
  // per-cycle m_ready pattern, until n inputs and nout outputs have moved.
  task automatic run_dir(input int d, input int n, input logic [15:0] rpat, input int nout);
    int i, cyc;
    i = 0; cyc = 0; outn[d] = 0;
    for (int k = 0; k < 16; k++) outlog[d][k] = 16'hDEAD;
    while ((i < n || outn[d] < nout) && cyc < 60) begin
      @(negedge clk);
      s_valid[d] = (i < n);
      if (i < n) begin s_data[d] = dw[i]; s_last[d] = dl[i]; end
      else s_last[d] = 1'b0;
      m_ready[d] = (cyc < 16) ? rpat[cyc] : 1'b1;
      #1;
      if (s_valid[d] && s_ready[d]) i++;
      cyc++;
      #2;
    end
    @(negedge clk);
    s_valid[d] = 1'b0; s_last[d] = 1'b0; m_ready[d] = 1'b1;
    chk("dir_done", d, 16'(cyc < 60), 16'h1);
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      s_valid[d] = 1'b0; s_last[d] = 1'b0; m_ready[d] = 1'b1; s_data[d] = '0; acc[d] = 1'b0;
    end
    for (int k = 0; k < 8; k++) dl[k] = 1'b0;
    repeat (3) @(negedge clk);
    #3;
    rst_n = 1'b1;
    idle_drain();

    dw = '{16'h12, 16'h34, 16'h56, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    run_dir(0, 3, 16'hFFFD, 3);
    chk("eq_out0", 0, outlog[0][0], 16'h0012);
    chk("eq_out1", 0, outlog[0][1], 16'h0034);
    chk("eq_out2", 0, outlog[0][2], 16'h0056);

    dw = '{16'hA1, 16'h02, 16'hF3, 16'h04, 16'h05, 16'h06, 16'h07, 16'h08};
    run_dir(1, 8, 16'hFFFF, 2);
    chk("up_out0", 1, outlog[1][0], 16'h4321);
    chk("up_out1", 1, outlog[1][1], 16'h8765);

    dw = '{16'h01, 16'h02, 16'h03, 16'h04, 16'h05, 16'h06, 16'h07, 16'h08};
    run_dir(1, 8, 16'hFC00, 2);
    chk("up_bp_out0", 1, outlog[1][0], 16'h4321);
    chk("up_bp_out1", 1, outlog[1][1], 16'h8765);

    dw = '{16'hABCD, 16'h1234, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    run_dir(2, 2, 16'hFFFF, 4);
    chk("dn_out0", 2, outlog[2][0], 16'h00CD);
    chk("dn_out1", 2, outlog[2][1], 16'h00AB);
    chk("dn_out2", 2, outlog[2][2], 16'h0034);
    chk("dn_out3", 2, outlog[2][3], 16'h0012);
    chk("dn_no_bubble", 2, 16'(outcyc[2][3] - outcyc[2][0]), 16'h3);

    rand_phase(400, 90, 90);
    rand_phase(400, 50, 70);
    rand_phase(30, 0, 100);
    rand_phase(400, 100, 100);
    rand_phase(300, 10, 90);
    do_reset();
    idle_drain();

    dw = '{16'h01, 16'h02, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    run_dir(1, 2, 16'hFFFF, 0);
    do_reset();
    idle_drain();
    dw = '{16'h09, 16'h0A, 16'h0B, 16'h0C, 16'h0, 16'h0, 16'h0, 16'h0};
    run_dir(1, 4, 16'hFFFF, 1);
    chk("up_after_rst", 1, outlog[1][0], 16'hCBA9);

`ifdef STREAM_LANE_DWC_TLAST_EN
    dw = '{16'h01, 16'h02, 16'h03, 16'h04, 16'h05, 16'h06, 16'h0, 16'h0};
    dl[1] = 1'b1;
    run_dir(1, 6, 16'hFFFF, 2);
    dl[1] = 1'b0;
    chk("up_flush_data", 1, outlog[1][0], 16'h0021);
    chk("up_flush_last", 1, 16'(outlst[1][0]), 16'h1);
    chk("up_next_group", 1, outlog[1][1], 16'h6543);
    chk("up_next_last", 1, 16'(outlst[1][1]), 16'h0);
`endif

    rand_phase(300, 70, 50);
    idle_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
